// File: rtl/incdec_microsequencer_if.sv
// Handshake and control-strobe bundle between opcode fetch and the INC/DEC microsequencer.
// master drives the request side; slave is the sequencer itself.
interface incdec_microsequencer_if;
   logic       Start;
   logic [7:0] Opcode;
   logic       MemReady;
   logic       Busy;
   logic [3:0] TState;
   logic [2:0] RegSel;
   logic [1:0] PairSel;
   logic       RegWrite;
   logic       PairWriteLo;
   logic       PairWriteHi;
   logic       AluAdd;
   logic       AluSub;
   logic       FlagWrite;
   logic       AddrHL;
   logic       MemRead;
   logic       MemWrite;
   logic       DtWrite;
   logic       Done;
   logic       Illegal;

   modport master (
      output Start, Opcode, MemReady,
      input  Busy, TState, RegSel, PairSel, RegWrite, PairWriteLo, PairWriteHi,
             AluAdd, AluSub, FlagWrite, AddrHL, MemRead, MemWrite, DtWrite, Done, Illegal
   );

   modport slave (
      input  Start, Opcode, MemReady,
      output Busy, TState, RegSel, PairSel, RegWrite, PairWriteLo, PairWriteHi,
             AluAdd, AluSub, FlagWrite, AddrHL, MemRead, MemWrite, DtWrite, Done, Illegal
   );
endinterface

// File: rtl/incdec_microsequencer.sv
// Clocked INC/DEC r, INC/DEC (HL) and INC/DEC rr sequencer with its own T-state counter
// and MemReady-stretched memory accesses.
module incdec_microsequencer #(
   parameter int MEM_CYCLE_T = 3,
   parameter bit WAIT_EN     = 1'b1,
   parameter bit RP16_EN     = 1'b1
) (
   input logic              i_clk,
   input logic              i_notReset,
   incdec_microsequencer_if.slave io_bus
);
   typedef enum logic [2:0] {IDLE, EXEC, RD, ALU, WR, RPLO, RPHI} state_t;

   localparam int unsigned            LAST_I = MEM_CYCLE_T - 1;
   localparam logic [MEM_CYCLE_T-1:0] LAST   = LAST_I[MEM_CYCLE_T-1:0];

   state_t                 r_state;
   logic [MEM_CYCLE_T-1:0] r_cnt;
   logic                   r_dec;
   logic                   r_busy;
   logic [3:0]             r_tstate;
   logic [2:0]             r_regsel;
   logic [1:0]             r_pairsel;
   logic                   r_regwrite, r_pwlo, r_pwhi, r_add, r_sub, r_flag;
   logic                   r_addrhl, r_mrd, r_mwr, r_dt, r_done, r_ill;

   logic w_ready, w_last, w_r8, w_mem, w_r16, w_acc_end;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   assign w_ready = !WAIT_EN || io_bus.MemReady;
   assign w_last  = (r_cnt == LAST);
   assign w_r8    = (io_bus.Opcode[7:6] == 2'b00) && (io_bus.Opcode[2:1] == 2'b10) &&
                    (io_bus.Opcode[5:3] != 3'b110);
   assign w_mem   = (io_bus.Opcode[7:6] == 2'b00) && (io_bus.Opcode[2:1] == 2'b10) &&
                    (io_bus.Opcode[5:3] == 3'b110);
   assign w_r16   = RP16_EN && (io_bus.Opcode[7:6] == 2'b00) && (io_bus.Opcode[2:0] == 3'b011);
   assign w_acc_end = w_last && w_ready;

   always_ff @(posedge i_clk) begin
      if (!i_notReset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_dec      <= 1'b0;
         r_busy     <= 1'b0;
         r_tstate   <= 4'd0;
         r_regsel   <= 3'd0;
         r_pairsel  <= 2'd0;
         r_regwrite <= 1'b0; r_pwlo <= 1'b0; r_pwhi <= 1'b0;
         r_add      <= 1'b0; r_sub  <= 1'b0; r_flag <= 1'b0;
         r_addrhl   <= 1'b0; r_mrd  <= 1'b0; r_mwr  <= 1'b0;
         r_dt       <= 1'b0; r_done <= 1'b0; r_ill  <= 1'b0;
      end else begin
         // Strobes default low; each branch raises those of the state being entered.
         r_regwrite <= 1'b0; r_pwlo <= 1'b0; r_pwhi <= 1'b0;
         r_add      <= 1'b0; r_sub  <= 1'b0; r_flag <= 1'b0;
         r_addrhl   <= 1'b0; r_mrd  <= 1'b0; r_mwr  <= 1'b0;
         r_dt       <= 1'b0; r_done <= 1'b0; r_ill  <= 1'b0;
         r_busy     <= 1'b1;
         r_tstate   <= sat_inc(r_tstate);
         case (r_state)
            IDLE: begin
               r_busy   <= 1'b0;
               r_tstate <= 4'd0;
               if (io_bus.Start) begin
                  if (w_r8 || w_mem || w_r16) begin
                     r_busy    <= 1'b1;
                     r_tstate  <= 4'd1;
                     r_regsel  <= io_bus.Opcode[5:3];
                     r_pairsel <= io_bus.Opcode[5:4];
                     r_cnt     <= '0;
                  end
                  if (w_r8) begin
                     r_state    <= EXEC;
                     r_regwrite <= 1'b1;
                     r_flag     <= 1'b1;
                     r_add      <= !io_bus.Opcode[0];
                     r_sub      <= io_bus.Opcode[0];
                     r_done     <= 1'b1;
                  end else if (w_mem) begin
                     r_state  <= RD;
                     r_dec    <= io_bus.Opcode[0];
                     r_addrhl <= 1'b1;
                     r_mrd    <= 1'b1;
                  end else if (w_r16) begin
                     r_state <= RPLO;
                     r_dec   <= io_bus.Opcode[3];
                     r_pwlo  <= 1'b1;
                     r_add   <= !io_bus.Opcode[3];
                     r_sub   <= io_bus.Opcode[3];
                  end else begin
                     r_ill <= 1'b1;
                  end
               end
            end
            RD: begin
               r_addrhl <= 1'b1;
               r_mrd    <= 1'b1;
               if (!w_last) begin
                  r_cnt <= r_cnt + 1'b1;
               end else if (w_ready) begin
                  r_state  <= ALU;
                  r_addrhl <= 1'b0;
                  r_mrd    <= 1'b0;
                  r_add    <= !r_dec;
                  r_sub    <= r_dec;
                  r_flag   <= 1'b1;
                  r_dt     <= 1'b1;
               end
            end
            ALU: begin
               r_state  <= WR;
               r_cnt    <= '0;
               r_addrhl <= 1'b1;
               r_mwr    <= 1'b1;
            end
            WR: begin
               r_addrhl <= 1'b1;
               r_mwr    <= 1'b1;
               if (!w_last) begin
                  r_cnt <= r_cnt + 1'b1;
               end else if (w_ready) begin
                  r_state  <= IDLE;
                  r_busy   <= 1'b0;
                  r_tstate <= 4'd0;
                  r_addrhl <= 1'b0;
                  r_mwr    <= 1'b0;
               end
            end
            RPLO: begin
               r_state <= RPHI;
               r_pwhi  <= 1'b1;
               r_add   <= !r_dec;
               r_sub   <= r_dec;
               r_done  <= 1'b1;
            end
            default: begin
               r_state  <= IDLE;
               r_busy   <= 1'b0;
               r_tstate <= 4'd0;
            end
         endcase
      end
   end

   // The access-completing strobes must follow MemReady within the same cycle, so the
   // registered state is qualified by the live handshake here.
   assign io_bus.DtWrite = r_dt   || ((r_state == RD) && w_acc_end);
   assign io_bus.Done    = r_done || ((r_state == WR) && w_acc_end);

   assign io_bus.Busy        = r_busy;
   assign io_bus.TState      = r_tstate;
   assign io_bus.RegSel      = r_regsel;
   assign io_bus.PairSel     = r_pairsel;
   assign io_bus.RegWrite    = r_regwrite;
   assign io_bus.PairWriteLo = r_pwlo;
   assign io_bus.PairWriteHi = r_pwhi;
   assign io_bus.AluAdd      = r_add;
   assign io_bus.AluSub      = r_sub;
   assign io_bus.FlagWrite   = r_flag;
   assign io_bus.AddrHL      = r_addrhl;
   assign io_bus.MemRead     = r_mrd;
   assign io_bus.MemWrite    = r_mwr;
   assign io_bus.Illegal     = r_ill;
endmodule

// File: tb/tb_incdec_microsequencer.sv
// Bench for incdec_microsequencer: two configurations driven in lockstep, each compared
// every cycle with a cycle-index reference model, plus directed vectors and sequences.
module tb_incdec_microsequencer;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   incdec_microsequencer_if bus_a ();
   incdec_microsequencer_if bus_b ();

   incdec_microsequencer #(.MEM_CYCLE_T(3), .WAIT_EN(1'b1), .RP16_EN(1'b1)) dut_a (
      .i_clk(clk), .i_notReset(rstn), .io_bus(bus_a));
   incdec_microsequencer #(.MEM_CYCLE_T(1), .WAIT_EN(1'b0), .RP16_EN(1'b0)) dut_b (
      .i_clk(clk), .i_notReset(rstn), .io_bus(bus_b));

   typedef struct packed {
      logic       busy;
      logic [3:0] ts;
      logic [2:0] rs;
      logic [1:0] ps;
      logic rw, pwl, pwh, add, sub, fw, ahl, mrd, mwr, dt, done, ill;
   } out_t;

   // kind: 0 = 8-bit register, 1 = (HL), 2 = register pair
   typedef struct {
      bit         busy;
      int         kind;
      bit         dec;
      int         t;
      logic [2:0] rs;
      logic [1:0] ps;
      int         srd;
      int         swr;
      bit         ill;
   } mst_t;

   typedef struct {
      logic [7:0] op;
      out_t       exp;
   } vec_t;

   out_t w_a, w_b, obs_a, obs_b;
   mst_t ma, mb;
   int   checks = 0;
   int   errors = 0;

   assign w_a = {bus_a.Busy, bus_a.TState, bus_a.RegSel, bus_a.PairSel, bus_a.RegWrite,
                 bus_a.PairWriteLo, bus_a.PairWriteHi, bus_a.AluAdd, bus_a.AluSub, bus_a.FlagWrite,
                 bus_a.AddrHL, bus_a.MemRead, bus_a.MemWrite, bus_a.DtWrite, bus_a.Done, bus_a.Illegal};
   assign w_b = {bus_b.Busy, bus_b.TState, bus_b.RegSel, bus_b.PairSel, bus_b.RegWrite,
                 bus_b.PairWriteLo, bus_b.PairWriteHi, bus_b.AluAdd, bus_b.AluSub, bus_b.FlagWrite,
                 bus_b.AddrHL, bus_b.MemRead, bus_b.MemWrite, bus_b.DtWrite, bus_b.Done, bus_b.Illegal};

   // Expected outputs of the current cycle from the cycle index t and the stalls seen so far.
   function automatic out_t predict(mst_t s, int mct, bit wen, bit mr);
      out_t o;
      bit   rdy;
      int   rd_end, wr_end;
      o = '0;
      rdy = !wen || mr;
      o.rs = s.rs;
      o.ps = s.ps;
      if (!s.busy) begin
         o.ill = s.ill;
         return o;
      end
      o.busy = 1'b1;
      o.ts = (s.t > 15) ? 4'd15 : 4'(s.t);
      o.add = !s.dec;
      o.sub = s.dec;
      if (s.kind == 0) begin
         o.rw = 1'b1; o.fw = 1'b1; o.done = 1'b1;
      end else if (s.kind == 2) begin
         if (s.t == 1) o.pwl = 1'b1;
         else begin o.pwh = 1'b1; o.done = 1'b1; end
      end else begin
         rd_end = mct + s.srd;
         wr_end = rd_end + 1 + mct + s.swr;
         if (s.t == rd_end + 1) begin
            o.fw = 1'b1; o.dt = 1'b1;
         end else begin
            o.add = 1'b0; o.sub = 1'b0; o.ahl = 1'b1;
            if (s.t <= rd_end) begin
               o.mrd = 1'b1; o.dt = (s.t == rd_end) && rdy;
            end else begin
               o.mwr = 1'b1; o.done = (s.t == wr_end) && rdy;
            end
         end
      end
      return o;
   endfunction

   function automatic mst_t advance(mst_t s, int mct, bit wen, bit rp16, bit rn,
                                    bit st, logic [7:0] op, bit mr);
      mst_t n;
      bit   rdy, fin;
      int   rd_end, wr_end;
      n = s;
      rdy = !wen || mr;
      if (!rn) begin
         n = '{default: 0};
         return n;
      end
      if (!s.busy) begin
         n.ill = 1'b0;
         if (st) begin
            if (op ==? 8'b00???10?) begin
               n.kind = (op[5:3] == 3'd6) ? 1 : 0;
               n.dec = op[0];
               n.busy = 1'b1;
            end else if (rp16 && (op ==? 8'b00??_?011)) begin
               n.kind = 2;
               n.dec = op[3];
               n.busy = 1'b1;
            end else begin
               n.ill = 1'b1;
            end
            if (n.busy) begin
               n.t = 1; n.rs = op[5:3]; n.ps = op[5:4]; n.srd = 0; n.swr = 0;
            end
         end
         return n;
      end
      rd_end = mct + s.srd;
      wr_end = rd_end + 1 + mct + s.swr;
      if (s.kind == 0) fin = 1'b1;
      else if (s.kind == 2) fin = (s.t == 2);
      else begin
         fin = (s.t == wr_end) && rdy;
         if (s.t == rd_end && !rdy) n.srd = s.srd + 1;
         if (s.t == wr_end && !rdy) n.swr = s.swr + 1;
      end
      if (fin) begin n.busy = 1'b0; n.t = 0; end
      else n.t = s.t + 1;
      return n;
   endfunction

   task automatic check(string name, out_t got, out_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, compare, advance the models.
   task automatic step(bit st, logic [7:0] op, bit mr, bit rn);
      bus_a.Start = st; bus_a.Opcode = op; bus_a.MemReady = mr;
      bus_b.Start = st; bus_b.Opcode = op; bus_b.MemReady = mr;
      rstn = rn;
      #1;
      obs_a = w_a;
      obs_b = w_b;
      check("model_a", obs_a, predict(ma, 3, 1'b1, mr));
      check("model_b", obs_b, predict(mb, 1, 1'b0, mr));
      ma = advance(ma, 3, 1'b1, 1'b1, rn, st, op, mr);
      mb = advance(mb, 1, 1'b0, 1'b0, rn, st, op, mr);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && (ma.busy || mb.busy); k++) step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0].op = 8'h04; vecs[0].exp = '{busy:1'b1, ts:4'd1, rw:1'b1, fw:1'b1, add:1'b1, done:1'b1, default:'0};
      vecs[1].op = 8'h0D; vecs[1].exp = '{busy:1'b1, ts:4'd1, rs:3'd1, rw:1'b1, fw:1'b1, sub:1'b1, done:1'b1, default:'0};
      vecs[2].op = 8'h3C; vecs[2].exp = '{busy:1'b1, ts:4'd1, rs:3'd7, ps:2'd3, rw:1'b1, fw:1'b1, add:1'b1, done:1'b1, default:'0};
      vecs[3].op = 8'h35; vecs[3].exp = '{busy:1'b1, ts:4'd1, rs:3'd6, ps:2'd3, ahl:1'b1, mrd:1'b1, default:'0};
      vecs[4].op = 8'h33; vecs[4].exp = '{busy:1'b1, ts:4'd1, rs:3'd6, ps:2'd3, pwl:1'b1, add:1'b1, default:'0};
      vecs[5].op = 8'h2B; vecs[5].exp = '{busy:1'b1, ts:4'd1, rs:3'd5, ps:2'd2, pwl:1'b1, sub:1'b1, default:'0};
      vecs[6].op = 8'h00; vecs[6].exp = '{rs:3'd5, ps:2'd2, ill:1'b1, default:'0};
      vecs[7].op = 8'h76; vecs[7].exp = '{rs:3'd5, ps:2'd2, ill:1'b1, default:'0};

      rstn = 1'b0;
      bus_a.Start = 1'b0; bus_a.Opcode = 8'h00; bus_a.MemReady = 1'b1;
      bus_b.Start = 1'b0; bus_b.Opcode = 8'h00; bus_b.MemReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ma = '{default: 0};
      mb = '{default: 0};

      for (int c = 0; c < 3; c++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         check("reset_a", obs_a, '0);
         check("reset_b", obs_b, '0);
      end

      for (int v = 0; v < 8; v++) begin
         step(1'b1, vecs[v].op, 1'b1, 1'b1);
         step(1'b0, 8'h00, 1'b1, 1'b1);
         check($sformatf("vec_%02h", vecs[v].op), obs_a, vecs[v].exp);
         drain();
      end

      // DEC (HL) with memory always ready
      step(1'b1, 8'h35, 1'b1, 1'b1);
      for (int c = 1; c <= 7; c++) begin
         step(1'b0, 8'h00, 1'b1, 1'b1);
         chk($sformatf("decHL_c%0d", c),
             {obs_a.mrd, obs_a.ahl, obs_a.mwr, obs_a.dt, obs_a.sub, obs_a.add, obs_a.done},
             {c <= 3, c != 4, c >= 5, (c == 3 || c == 4), c == 4, 1'b0, c == 7});
         chk($sformatf("decHL_ts%0d", c), obs_a.ts, c);
      end
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("decHL_idle", obs_a.busy, 0);
      drain();

      // INC (HL) with MemReady low in cycles 3-5
      step(1'b1, 8'h34, 1'b1, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         step(1'b0, 8'h00, !(c >= 3 && c <= 5), 1'b1);
         chk($sformatf("stall_c%0d", c), {obs_a.mrd, obs_a.dt, obs_a.add, obs_a.done},
             {c <= 6, (c == 6 || c == 7), c == 7, c == 10});
      end
      chk("stall_done_ts", obs_a.ts, 10);
      drain();

      // INC SP, and the same opcode on the configuration without pair support
      step(1'b1, 8'h33, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("incsp_c1", {obs_a.busy, obs_a.pwl, obs_a.pwh, obs_a.add, obs_a.fw, obs_a.done, obs_a.ps},
          {6'b110100, 2'd3});
      chk("incsp_b_ill", {obs_b.busy, obs_b.ill}, 2'b01);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("incsp_c2", {obs_a.busy, obs_a.pwl, obs_a.pwh, obs_a.add, obs_a.fw, obs_a.done}, 6'b101101);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("incsp_idle", obs_a.busy, 0);
      drain();

      // Start held high through an (HL) op, including its Done cycle
      step(1'b1, 8'h34, 1'b1, 1'b1);
      for (int c = 1; c <= 7; c++) begin
         step(1'b1, 8'h04, 1'b1, 1'b1);
         chk($sformatf("held_c%0d", c), {obs_a.busy, obs_a.rs, obs_a.done}, {1'b1, 3'd6, c == 7});
      end
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("held_after_done", obs_a.busy, 0);
      drain();

      // Reset asserted in the first WR cycle, then INC A
      step(1'b1, 8'h35, 1'b1, 1'b1);
      for (int c = 1; c <= 4; c++) step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rstwr_in_wr", obs_a.mwr, 1);
      step(1'b1, 8'h3C, 1'b1, 1'b1);
      check("rstwr_cleared", obs_a, '0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("rstwr_inca", {obs_a.busy, obs_a.rs, obs_a.rw, obs_a.add}, {1'b1, 3'd7, 2'b11});
      drain();

      for (int i = 0; i < 600; i++) begin
         logic [7:0] op;
         int         sel;
         sel = $urandom_range(0, 3);
         case (sel)
            0: op = 8'($urandom);
            1: op = {2'b00, 3'($urandom), 2'b10, 1'($urandom)};
            2: op = {2'b00, 3'b110, 2'b10, 1'($urandom)};
            default: op = {2'b00, 2'($urandom), 1'($urandom), 3'b011};
         endcase
         step($urandom_range(0, 2) == 0, op, $urandom_range(0, 3) != 0, $urandom_range(0, 63) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
